// File: rtl/bch_syndrome_remainder_multi.sv
// bch_syndrome_remainder_multi
//   Computes r(x) mod f_k(x) for NUM_SYN minimal polynomials in parallel,
//   consuming a DATA_LEN-bit codeword BITS bits per beat (MSB first).
//
// Ports
//   clk        sole clock, rising edge
//   reset      synchronous, active-high
//   start      current beat is the first beat of a codeword
//   in_valid   data_in valid this cycle
//   in_ready   block accepts a beat this cycle
//   data_in    BITS codeword bits, data_in[BITS-1] is highest order
//   out_valid  rem_out / nonzero hold a completed result
//   out_ready  consumer accepts the result
//   rem_out    NUM_SYN*M bits, slice k = r(x) mod f_k(x)
//   nonzero    OR of all remainder bits
module bch_syndrome_remainder_multi #(
  parameter int M        = 4,
  parameter int NUM_SYN  = 2,
  parameter logic [NUM_SYN*(M+1)-1:0] SYN_POLYS = {5'h1F, 5'h13},
  parameter int DATA_LEN = 15,
  parameter int BITS     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BITS-1:0]        data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_SYN*M-1:0]   rem_out,
  output logic                   nonzero
);

  if (DATA_LEN % BITS != 0) begin : g_bad_bits
    $error("DATA_LEN must be a multiple of BITS");
  end

  localparam int NBEATS = DATA_LEN / BITS;
  localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  // Shift BITS data bits into a remainder register, reducing mod f after
  // each bit; poly excludes the implicit monic x^M term.
  function automatic logic [M-1:0] shift_in(input logic [M-1:0] st,
                                            input logic [BITS-1:0] d,
                                            input logic [M-1:0] poly);
    logic [M-1:0] s;
    logic         fb;
    s = st;
    for (int unsigned j = 0; j < BITS; j++) begin
      fb = s[M-1];
      s  = {s[M-2:0], d[BITS-1-j]} ^ ({M{fb}} & poly);
    end
    return s;
  endfunction

  logic [M-1:0]          lfsr     [NUM_SYN];
  logic [M-1:0]          step_val [NUM_SYN];
  logic [NUM_SYN*M-1:0]  final_rem;
  logic [CW-1:0]         cnt;
  logic                  active;
  logic                  accept;
  logic                  last_beat;
  logic                  take_last;

  always_comb begin
    final_rem = '0;
    for (int unsigned k = 0; k < NUM_SYN; k++) begin
      // start discards prior state: reduce data_in alone
      step_val[k] = shift_in(start ? '0 : lfsr[k], data_in,
                             SYN_POLYS[k*(M+1) +: M]);
      final_rem[k*M +: M] = step_val[k];
    end
  end

  // Only the beat that would complete a frame is ever stalled; dropped and
  // restarting beats are not last beats.
  always_comb begin
    last_beat = (start && (NBEATS == 1)) ||
                (!start && active && (cnt == CW'(NBEATS - 1)));
    in_ready  = !(out_valid && !out_ready && last_beat);
    accept    = in_valid && in_ready;
    take_last = accept && last_beat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_SYN; k++) lfsr[k] <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      rem_out   <= '0;
      nonzero   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (accept && (start || active)) begin
        for (int unsigned k = 0; k < NUM_SYN; k++) lfsr[k] <= step_val[k];
      end
      if (take_last) begin
        active    <= 1'b0;
        cnt       <= '0;
        rem_out   <= final_rem;
        nonzero   <= |final_rem;
        out_valid <= 1'b1;
      end else begin
        if (accept && start) begin
          active <= 1'b1;
          cnt    <= CW'(1);
        end else if (accept && active) begin
          cnt <= cnt + CW'(1);
        end
        if (out_valid && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_syndrome_remainder_multi.sv
module tb_bch_syndrome_remainder_multi;

  logic       clk = 1'b0;
  logic       reset;
  // BITS=1 instance
  logic       start1, valid1, ready1, ovalid1, oready1, nz1;
  logic [0:0] data1;
  logic [7:0] rem1;
  // BITS=3 instance
  logic       start3, valid3, ready3, ovalid3, oready3, nz3;
  logic [2:0] data3;
  logic [7:0] rem3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bch_syndrome_remainder_multi #(.M(4), .NUM_SYN(2), .SYN_POLYS(10'({5'h1F, 5'h13})),
    .DATA_LEN(15), .BITS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(valid1), .in_ready(ready1),
    .data_in(data1), .out_valid(ovalid1), .out_ready(oready1), .rem_out(rem1), .nonzero(nz1));

  bch_syndrome_remainder_multi #(.M(4), .NUM_SYN(2), .SYN_POLYS(10'({5'h1F, 5'h13})),
    .DATA_LEN(15), .BITS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .in_valid(valid3), .in_ready(ready3),
    .data_in(data3), .out_valid(ovalid3), .out_ready(oready3), .rem_out(rem3), .nonzero(nz3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat1(input logic st, input logic d);
    int n;
    @(negedge clk);
    start1 = st; valid1 = 1'b1; data1 = d;
    #1;
    n = 0;
    while (!ready1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("ready1_timeout", ready1, 1);
    @(posedge clk);
  endtask

  task automatic beat3(input logic st, input logic [2:0] d);
    int n;
    @(negedge clk);
    start3 = st; valid3 = 1'b1; data3 = d;
    #1;
    n = 0;
    while (!ready3 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) check("ready3_timeout", ready3, 1);
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    valid1 = 1'b0; start1 = 1'b0; valid3 = 1'b0; start3 = 1'b0;
    #1;
  endtask

  // Sends the nb highest-order bits of cw, start on the first.
  task automatic frame1(input logic [14:0] cw, input int nb);
    for (int i = 0; i < nb; i++) beat1(i == 0, cw[14-i]);
  endtask

  initial begin
    reset = 1'b1;
    start1 = 0; valid1 = 0; data1 = '0; oready1 = 1;
    start3 = 0; valid3 = 0; data3 = '0; oready3 = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ovalid", ovalid1, 0);
    check("reset_rem", rem1, 8'h00);
    check("reset_nz", nz1, 0);
    check("reset_ready", ready1, 1);

    // all-zero codeword
    frame1(15'h0000, 15); idle();
    check("zero_ovalid", ovalid1, 1);
    check("zero_rem", rem1, 8'h00);
    check("zero_nz", nz1, 0);

    // x^4: mod 1F -> F, mod 13 -> 3
    frame1(15'h0010, 15); idle();
    check("x4_ovalid", ovalid1, 1);
    check("x4_rem", rem1, 8'hF3);
    check("x4_nz", nz1, 1);
    @(negedge clk);
    check("x4_consumed", ovalid1, 0);

    // x^14 = x^-1: mod 1F -> F, mod 13 -> 9
    frame1(15'h4000, 15); idle();
    check("x14_rem", rem1, 8'hF9);

    // all ones: (x^15-1)/(x-1) divisible by both
    frame1(15'h7FFF, 15); idle();
    check("ones_rem", rem1, 8'h00);
    check("ones_nz", nz1, 0);

    // x^5: mod 1F -> 1, mod 13 -> 6
    frame1(15'h0020, 15); idle();
    check("x5_rem", rem1, 8'h16);

    // BITS=3: x^0 on 5th beat
    beat3(1, 3'b000); beat3(0, 3'b000); beat3(0, 3'b000); beat3(0, 3'b000);
    idle();
    check("b3_not_done", ovalid3, 0);
    beat3(0, 3'b001); idle();
    check("b3_x0_ovalid", ovalid3, 1);
    check("b3_x0_rem", rem3, 8'h11);
    // BITS=3: x^14 in first beat
    beat3(1, 3'b100); beat3(0, 3'b000); beat3(0, 3'b000); beat3(0, 3'b000);
    beat3(0, 3'b000); idle();
    check("b3_x14_rem", rem3, 8'hF9);

    // backpressure: first result held, second last beat stalled
    @(negedge clk);
    oready1 = 0;
    frame1(15'h0010, 15); idle();
    check("bp_first_rem", rem1, 8'hF3);
    frame1(15'h4000, 14);
    @(negedge clk);
    start1 = 0; valid1 = 1; data1 = 1'b0;
    #1;
    check("bp_stall_ready", ready1, 0);
    @(negedge clk); #1;
    check("bp_hold_ovalid", ovalid1, 1);
    check("bp_hold_rem", rem1, 8'hF3);
    check("bp_still_stalled", ready1, 0);
    oready1 = 1;
    #1;
    check("bp_release_ready", ready1, 1);
    @(posedge clk);
    idle();
    check("bp_second_ovalid", ovalid1, 1);
    check("bp_second_rem", rem1, 8'hF9);
    @(negedge clk);
    check("bp_second_consumed", ovalid1, 0);

    // reset at beat 7
    frame1(15'h0010, 7); idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_mid_ovalid", ovalid1, 0);
    check("rst_mid_rem", rem1, 8'h00);
    check("rst_mid_ready", ready1, 1);
    for (int i = 0; i < 8; i++) beat1(0, 1'b1);
    idle();
    check("rst_no_spurious", ovalid1, 0);
    frame1(15'h0020, 15); idle();
    check("rst_new_rem", rem1, 8'h16);
    @(negedge clk);

    // start at beat 9 aborts; hold out_ready low so a spurious result would stick
    oready1 = 0;
    frame1(15'h0010, 9); idle();
    frame1(15'h4000, 14); idle();
    check("abort_no_ovalid", ovalid1, 0);
    beat1(0, 1'b0); idle();
    check("abort_ovalid", ovalid1, 1);
    check("abort_rem", rem1, 8'hF9);
    oready1 = 1;
    @(negedge clk);

    // non-start beats while idle are dropped
    for (int i = 0; i < 15; i++) beat1(0, 1'b1);
    idle();
    check("drop_ovalid", ovalid1, 0);
    frame1(15'h0010, 15); idle();
    check("drop_then_rem", rem1, 8'hF3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
